// File: rtl/route_demux.sv
// route_demux: 1-to-2 demultiplexer with a single-entry holding register per
// output port and a free-running transfer counter per port.
module route_demux #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNTW  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sel,
  input  logic [WIDTH-1:0] in_data,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic [CNTW-1:0]  cnt0,
  output logic [CNTW-1:0]  cnt1
);

  logic [1:0]       valid_q, valid_d;
  logic [WIDTH-1:0] data0_q, data0_d;
  logic [WIDTH-1:0] data1_q, data1_d;
  logic [CNTW-1:0]  cnt0_q, cnt0_d;
  logic [CNTW-1:0]  cnt1_q, cnt1_d;
  logic [1:0]       out_fire;
  logic [1:0]       wr_en;
  logic             in_fire;

  // Upstream ready depends only on the selected port, so a stalled port never blocks the other.
  always_comb begin
    in_ready = in_sel ? (~valid_q[1] | out1_ready) : (~valid_q[0] | out0_ready);
  end

  // Transfer strobes for the input side and each output port.
  always_comb begin
    in_fire  = in_valid & in_ready;
    out_fire = {valid_q[1] & out1_ready, valid_q[0] & out0_ready};
    wr_en    = {in_sel, ~in_sel} & {2{in_fire}};
  end

  // Next-state: a write wins over a drain so pass-through keeps valid high.
  always_comb begin
    valid_d = valid_q;
    data0_d = data0_q;
    data1_d = data1_q;
    cnt0_d  = cnt0_q + CNTW'(out_fire[0]);
    cnt1_d  = cnt1_q + CNTW'(out_fire[1]);
    if (out_fire[0]) valid_d[0] = 1'b0;
    if (out_fire[1]) valid_d[1] = 1'b0;
    if (wr_en[0]) begin
      valid_d[0] = 1'b1;
      data0_d    = in_data;
    end
    if (wr_en[1]) begin
      valid_d[1] = 1'b1;
      data1_d    = in_data;
    end
  end

  // State registers; reset discards held words and clears the counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      data0_q <= '0;
      data1_q <= '0;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data0_q <= data0_d;
      data1_q <= data1_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
    end
  end

  assign out0_valid = valid_q[0];
  assign out1_valid = valid_q[1];
  assign out0_data  = data0_q;
  assign out1_data  = data1_q;
  assign cnt0       = cnt0_q;
  assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_route_demux.sv
// Testbench for route_demux: directed vector table, randomized traffic against a
// queue-based reference model, and a counter wrap run.
module tb_route_demux;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        out0_valid, out1_valid;
  logic        out0_ready, out1_ready;
  logic [31:0] out0_data, out1_data;
  logic [15:0] cnt0, cnt1;

  int n_chk  = 0;
  int n_pass = 0;

  route_demux #(.WIDTH(32), .CNTW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  // Reference model: each port is a queue of accepted-but-undelivered words,
  // plus the last word written (what the register shows) and a delivery count.
  logic [31:0] mq0[$];
  logic [31:0] mq1[$];
  logic [31:0] mlast0, mlast1;
  int unsigned mcnt0, mcnt1;

  typedef struct {
    logic        rst;
    logic        iv;
    logic        sel;
    logic [31:0] d;
    logic        r0;
    logic        r1;
    logic        e_rdy;
    logic        e_v0;
    logic [31:0] e_d0;
    logic        e_v1;
    logic [31:0] e_d1;
    logic [15:0] e_c0;
    logic [15:0] e_c1;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input logic rst, input logic iv, input logic sel,
                       input logic [31:0] d, input logic r0, input logic r1);
    reset      = rst;
    in_valid   = iv;
    in_sel     = sel;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
  endtask

  // Called mid-cycle: optionally compare DUT to the model, clock one edge,
  // advance the model from the inputs that were present at that edge.
  task automatic step(input bit do_chk, input string tag);
    bit exp_rdy;
    bit f0, f1;
    exp_rdy = in_sel ? (mq1.size() == 0 || out1_ready) : (mq0.size() == 0 || out0_ready);
    if (do_chk) begin
      chk({tag, " in_ready"},   32'(in_ready),   32'(exp_rdy));
      chk({tag, " out0_valid"}, 32'(out0_valid), 32'(mq0.size() != 0));
      chk({tag, " out1_valid"}, 32'(out1_valid), 32'(mq1.size() != 0));
      chk({tag, " out0_data"},  out0_data, mlast0);
      chk({tag, " out1_data"},  out1_data, mlast1);
      chk({tag, " cnt0"},       32'(cnt0), mcnt0 % 32'h10000);
      chk({tag, " cnt1"},       32'(cnt1), mcnt1 % 32'h10000);
    end
    f0 = (mq0.size() != 0) && out0_ready;
    f1 = (mq1.size() != 0) && out1_ready;
    @(posedge clk);
    if (reset) begin
      mq0.delete();
      mq1.delete();
      mlast0 = '0;
      mlast1 = '0;
      mcnt0  = 0;
      mcnt1  = 0;
    end else begin
      if (f0) begin void'(mq0.pop_front()); mcnt0++; end
      if (f1) begin void'(mq1.pop_front()); mcnt1++; end
      if (in_valid && exp_rdy) begin
        if (in_sel) begin mq1.push_back(in_data); mlast1 = in_data; end
        else        begin mq0.push_back(in_data); mlast0 = in_data; end
      end
    end
    #1;
  endtask

  initial begin
    // rst iv sel data r0 r1 | rdy v0 d0 v1 d1 c0 c1
    tbl[0]  = '{1'b0,1'b1,1'b0,32'hDEADBEEF,1'b0,1'b0, 1'b1,1'b0,32'h0,       1'b0,32'h0,       16'd0,16'd0};
    tbl[1]  = '{1'b0,1'b1,1'b0,32'h11111111,1'b0,1'b0, 1'b0,1'b1,32'hDEADBEEF,1'b0,32'h0,       16'd0,16'd0};
    tbl[2]  = '{1'b0,1'b1,1'b1,32'h12345678,1'b0,1'b1, 1'b1,1'b1,32'hDEADBEEF,1'b0,32'h0,       16'd0,16'd0};
    tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,       1'b0,1'b1, 1'b0,1'b1,32'hDEADBEEF,1'b1,32'h12345678,16'd0,16'd0};
    tbl[4]  = '{1'b0,1'b1,1'b1,32'h1,       1'b0,1'b1, 1'b1,1'b1,32'hDEADBEEF,1'b0,32'h12345678,16'd0,16'd1};
    tbl[5]  = '{1'b0,1'b1,1'b1,32'h2,       1'b0,1'b1, 1'b1,1'b1,32'hDEADBEEF,1'b1,32'h1,       16'd0,16'd1};
    tbl[6]  = '{1'b0,1'b1,1'b1,32'h3,       1'b0,1'b1, 1'b1,1'b1,32'hDEADBEEF,1'b1,32'h2,       16'd0,16'd2};
    tbl[7]  = '{1'b0,1'b1,1'b1,32'h4,       1'b0,1'b1, 1'b1,1'b1,32'hDEADBEEF,1'b1,32'h3,       16'd0,16'd3};
    tbl[8]  = '{1'b0,1'b0,1'b1,32'h0,       1'b0,1'b1, 1'b1,1'b1,32'hDEADBEEF,1'b1,32'h4,       16'd0,16'd4};
    tbl[9]  = '{1'b0,1'b1,1'b0,32'hA,       1'b1,1'b0, 1'b1,1'b1,32'hDEADBEEF,1'b0,32'h4,       16'd0,16'd5};
    tbl[10] = '{1'b0,1'b1,1'b0,32'hB,       1'b1,1'b0, 1'b1,1'b1,32'hA,       1'b0,32'h4,       16'd1,16'd5};
    tbl[11] = '{1'b0,1'b1,1'b0,32'h5,       1'b1,1'b0, 1'b1,1'b1,32'hB,       1'b0,32'h4,       16'd2,16'd5};
    tbl[12] = '{1'b0,1'b1,1'b1,32'h6,       1'b0,1'b0, 1'b1,1'b1,32'h5,       1'b0,32'h4,       16'd3,16'd5};
    tbl[13] = '{1'b0,1'b0,1'b1,32'hFFFFFFFF,1'b0,1'b0, 1'b0,1'b1,32'h5,       1'b1,32'h6,       16'd3,16'd5};
    tbl[14] = '{1'b1,1'b1,1'b0,32'h77,      1'b1,1'b1, 1'b1,1'b1,32'h5,       1'b1,32'h6,       16'd3,16'd5};
    tbl[15] = '{1'b0,1'b0,1'b0,32'h0,       1'b1,1'b1, 1'b1,1'b0,32'h0,       1'b0,32'h0,       16'd0,16'd0};

    mlast0 = '0; mlast1 = '0; mcnt0 = 0; mcnt1 = 0;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    step(1'b0, "rst");
    step(1'b1, "post_rst");

    // Directed vectors, checked against hand-derived expectations and the model.
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].sel, tbl[i].d, tbl[i].r0, tbl[i].r1);
      #4;
      chk($sformatf("vec%0d in_ready", i),   32'(in_ready),   32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d out0_valid", i), 32'(out0_valid), 32'(tbl[i].e_v0));
      chk($sformatf("vec%0d out0_data", i),  out0_data,       tbl[i].e_d0);
      chk($sformatf("vec%0d out1_valid", i), 32'(out1_valid), 32'(tbl[i].e_v1));
      chk($sformatf("vec%0d out1_data", i),  out1_data,       tbl[i].e_d1);
      chk($sformatf("vec%0d cnt0", i),       32'(cnt0),       32'(tbl[i].e_c0));
      chk($sformatf("vec%0d cnt1", i),       32'(cnt1),       32'(tbl[i].e_c1));
      step(1'b1, $sformatf("vec%0d model", i));
    end

    // Randomized traffic with occasional reset.
    for (int i = 0; i < 3000; i++) begin
      drive(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom),
            $urandom, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      #4;
      step(1'b1, $sformatf("rnd%0d", i));
    end

    // Counter wrap: 65535 port-0 deliveries reach all-ones, one more wraps to zero.
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    #4; step(1'b0, "wrap_rst");
    for (int i = 0; i < 65535; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      #4; step(1'b0, "wrap_fill");
    end
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #4; step(1'b0, "wrap_drain");
    #4;
    chk("wrap cnt0 all-ones", 32'(cnt0), 32'h0000FFFF);
    chk("wrap out0_data last", out0_data, 32'h0000FFFE);
    step(1'b1, "wrap_ffff");
    drive(1'b0, 1'b1, 1'b0, 32'hCAFE0001, 1'b1, 1'b0);
    #4; step(1'b1, "wrap_push");
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    #4; step(1'b1, "wrap_pop");
    #4;
    chk("wrap cnt0 zero", 32'(cnt0), 32'h0);
    chk("wrap cnt1 zero", 32'(cnt1), 32'h0);
    step(1'b1, "wrap_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
